// File: rtl/npc_pkg.sv
// Shared types and constants for the NPC core front end.
package npc_pkg;

  localparam int unsigned      XLEN     = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h8000_0000;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  // One buffered fetch result handed to decode.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  // Fetch condition for the current cycle; derived combinationally, not stored.
  typedef enum logic [1:0] {
    ST_FETCH,
    ST_STALL,
    ST_HALTED
  } fetch_state_e;

endpackage : npc_pkg

// File: rtl/ifu_fifo.sv
// Small synchronous FIFO of {pc, inst} entries between fetch and decode.
// The head is presented from storage and forced to zero while empty.
module ifu_fifo
  import npc_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t wdata,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  fetch_entry_t     mem_q [DEPTH];

  logic do_push;
  logic do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  // Next-state for pointers and occupancy; flush wins over push/pop.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage written on push.
  // NOTE: storage is deliberately not reset; the head is masked while empty, so stale data never escapes.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule : ifu_fifo

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, addresses the ROM, buffers fetched
// words and hands them to decode. Supports redirect with flush and halt.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC   = npc_pkg::RESET_PC,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        misalign_err,
  output logic [31:0] fetch_cnt
);

  import npc_pkg::*;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     fetch_cnt_q, fetch_cnt_d;
  logic            misalign_q, misalign_d;

  fetch_state_e    state;
  logic            fire;
  logic            fifo_full;
  logic            fifo_empty;
  fetch_entry_t    fifo_wdata;
  fetch_entry_t    fifo_head;

  // Fetch condition this cycle: halt dominates, then a full buffer stalls.
  always_comb begin
    state = ST_FETCH;
    if (halt)           state = ST_HALTED;
    else if (fifo_full) state = ST_STALL;
  end

  // Redirect suppresses the enqueue regardless of state.
  assign fire = !redirect_valid && (state == ST_FETCH);

  // PC, fetch counter and misalign pulse next-state; redirect has top priority.
  always_comb begin
    pc_d        = pc_q;
    fetch_cnt_d = fetch_cnt_q;
    misalign_d  = redirect_valid && (redirect_pc[1:0] != 2'b00);
    if (redirect_valid) begin
      pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (fire) begin
      pc_d        = pc_q + 32'd4;
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
  end

  // PC, fetch counter and misalign registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      fetch_cnt_q <= '0;
      misalign_q  <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      fetch_cnt_q <= fetch_cnt_d;
      misalign_q  <= misalign_d;
    end
  end

  assign fifo_wdata = '{pc: pc_q, inst: inst_data};

  ifu_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fire),
    .wdata (fifo_wdata),
    .pop   (if_ready),
    .flush (redirect_valid),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  assign inst_addr    = pc_q;
  assign if_valid     = !fifo_empty;
  assign if_pc        = fifo_head.pc;
  assign if_inst      = fifo_head.inst;
  assign misalign_err = misalign_q;
  assign fetch_cnt    = fetch_cnt_q;

endmodule : ifu_fetch

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch. The ROM returns the word index relative to
// 0x8000_0000, so ROM[i] = i for the reset region.
module tb_ifu_fetch;

  logic        clk;
  logic        rst_n;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        misalign_err;
  logic [31:0] fetch_cnt;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  ifu_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .inst_addr      (inst_addr),
    .inst_data      (inst_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .misalign_err   (misalign_err),
    .fetch_cnt      (fetch_cnt)
  );

  // Zero-latency ROM model.
  assign inst_data = (inst_addr - 32'h8000_0000) >> 2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    halt           = 1'b0;
    if_ready       = 1'b1;

    // Reset state
    #12;
    check("rst_if_valid", {31'b0, if_valid}, 32'h0);
    check("rst_inst_addr", inst_addr, 32'h8000_0000);
    check("rst_fetch_cnt", fetch_cnt, 32'h0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_inst", if_inst, 32'h0);
    check("rst_misalign", {31'b0, misalign_err}, 32'h0);

    // Release away from an edge; streaming with if_ready high
    rst_n = 1'b1;
    #1;
    check("c0_inst_addr", inst_addr, 32'h8000_0000);
    check("c0_if_valid", {31'b0, if_valid}, 32'h0);
    step();
    check("c1_inst_addr", inst_addr, 32'h8000_0004);
    check("c1_if_valid", {31'b0, if_valid}, 32'h1);
    check("c1_if_pc", if_pc, 32'h8000_0000);
    check("c1_if_inst", if_inst, 32'h0);
    check("c1_fetch_cnt", fetch_cnt, 32'd1);
    step();
    check("c2_if_pc", if_pc, 32'h8000_0004);
    check("c2_if_inst", if_inst, 32'h1);
    check("c2_inst_addr", inst_addr, 32'h8000_0008);
    check("c2_fetch_cnt", fetch_cnt, 32'd2);

    // Back-pressure: one more enqueue fills the FIFO, then fetch stalls
    if_ready = 1'b0;
    step();
    check("bp1_inst_addr", inst_addr, 32'h8000_000C);
    check("bp1_if_pc", if_pc, 32'h8000_0004);
    steps(4);
    check("bp5_inst_addr", inst_addr, 32'h8000_000C);
    check("bp5_if_pc", if_pc, 32'h8000_0004);
    check("bp5_if_valid", {31'b0, if_valid}, 32'h1);
    check("bp5_fetch_cnt", fetch_cnt, 32'd3);

    // Release: full FIFO does not enqueue in the dequeue cycle
    if_ready = 1'b1;
    step();
    check("dr1_if_pc", if_pc, 32'h8000_0008);
    check("dr1_if_inst", if_inst, 32'h2);
    check("dr1_inst_addr", inst_addr, 32'h8000_000C);
    check("dr1_fetch_cnt", fetch_cnt, 32'd3);
    step();
    check("dr2_if_pc", if_pc, 32'h8000_000C);
    check("dr2_fetch_cnt", fetch_cnt, 32'd4);

    // Fill, then redirect while full
    if_ready = 1'b0;
    step();
    check("fill_if_pc", if_pc, 32'h8000_000C);
    check("fill_fetch_cnt", fetch_cnt, 32'd5);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    step();
    redirect_valid = 1'b0;
    if_ready       = 1'b1;
    check("rd_if_valid", {31'b0, if_valid}, 32'h0);
    check("rd_inst_addr", inst_addr, 32'h8000_0100);
    check("rd_misalign", {31'b0, misalign_err}, 32'h0);
    check("rd_fetch_cnt", fetch_cnt, 32'd5);
    step();
    check("rd2_if_pc", if_pc, 32'h8000_0100);
    check("rd2_if_inst", if_inst, 32'h40);

    // Misaligned redirect target
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0102;
    step();
    redirect_valid = 1'b0;
    check("mis_pulse", {31'b0, misalign_err}, 32'h1);
    check("mis_inst_addr", inst_addr, 32'h8000_0100);
    check("mis_if_valid", {31'b0, if_valid}, 32'h0);
    step();
    check("mis_clear", {31'b0, misalign_err}, 32'h0);
    check("mis_if_pc", if_pc, 32'h8000_0100);
    check("mis_fetch_cnt", fetch_cnt, 32'd7);

    // Halt mid-stream: drain, counter frozen, then resume sequentially
    halt = 1'b1;
    step();
    check("h1_if_valid", {31'b0, if_valid}, 32'h0);
    check("h1_fetch_cnt", fetch_cnt, 32'd7);
    check("h1_inst_addr", inst_addr, 32'h8000_0104);
    step();
    check("h2_fetch_cnt", fetch_cnt, 32'd7);
    halt = 1'b0;
    step();
    check("h3_if_pc", if_pc, 32'h8000_0104);
    check("h3_if_inst", if_inst, 32'h41);
    check("h3_fetch_cnt", fetch_cnt, 32'd8);

    // Redirect during halt
    halt           = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    step();
    redirect_valid = 1'b0;
    check("hr_if_valid", {31'b0, if_valid}, 32'h0);
    check("hr_inst_addr", inst_addr, 32'h8000_0200);
    step();
    check("hr2_if_valid", {31'b0, if_valid}, 32'h0);
    check("hr2_fetch_cnt", fetch_cnt, 32'd8);
    halt = 1'b0;
    step();
    check("hr3_if_pc", if_pc, 32'h8000_0200);
    check("hr3_if_inst", if_inst, 32'h80);
    check("hr3_fetch_cnt", fetch_cnt, 32'd9);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    check("wr_inst_addr", inst_addr, 32'hFFFF_FFFC);
    step();
    check("wr2_inst_addr", inst_addr, 32'h0000_0000);
    check("wr2_if_pc", if_pc, 32'hFFFF_FFFC);
    check("wr2_if_inst", if_inst, 32'h1FFF_FFFF);
    step();
    check("wr3_if_pc", if_pc, 32'h0000_0000);
    check("wr3_if_inst", if_inst, 32'h2000_0000);
    check("wr3_fetch_cnt", fetch_cnt, 32'd11);

    // Asynchronous reset between edges
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_if_valid", {31'b0, if_valid}, 32'h0);
    check("ar_inst_addr", inst_addr, 32'h8000_0000);
    check("ar_fetch_cnt", fetch_cnt, 32'h0);
    check("ar_if_pc", if_pc, 32'h0);

    // From reset with decode stalled: exactly two enqueues
    if_ready = 1'b0;
    #2;
    rst_n = 1'b1;
    steps(5);
    check("st_inst_addr", inst_addr, 32'h8000_0008);
    check("st_if_pc", if_pc, 32'h8000_0000);
    check("st_fetch_cnt", fetch_cnt, 32'd2);
    if_ready = 1'b1;
    step();
    check("sd1_if_pc", if_pc, 32'h8000_0004);
    check("sd1_if_inst", if_inst, 32'h1);
    check("sd1_inst_addr", inst_addr, 32'h8000_0008);
    step();
    check("sd2_if_pc", if_pc, 32'h8000_0008);
    check("sd2_if_inst", if_inst, 32'h2);
    check("sd2_fetch_cnt", fetch_cnt, 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule : tb_ifu_fetch
